// File: rtl/dlf_gain_shifter.sv
// rtl/dlf_gain_shifter.sv - registered DLF-to-VCO gain stage with rounding, saturation and gear-shift
//
// Purpose: selects an OUT_W-bit window of the unsigned loop-filter output by a
// programmable right shift. The window is rounded half-up or truncated, and it
// saturates when the shifted value does not fit. An optional auto gear mode
// raises the shift in steps after every GEAR_SAMPLES accepted samples, until
// the shift reaches gear_target.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   enable             low forces IDLE and clears the outputs
//   dlf_valid/dlf_out  input sample strobe and unsigned value
//   shift_req          manual shift, and the start shift for gear mode
//   shift_load         loads shift_req while in MANUAL
//   auto_gear          mode select, sampled when leaving IDLE
//   gear_target        final shift in gear mode
//   round_en           1 = round half up, 0 = truncate
//   vco_val/vco_valid  registered control word and its one-cycle strobe
//   cur_shift          active shift
//   sat                saturation flag, qualified by vco_valid
//   gear_done          high while in HOLD

module dlf_gain_shifter #(
    parameter int IN_W         = 12,
    parameter int OUT_W        = 5,
    parameter int SHIFT_W      = 3,
    parameter int GEAR_SAMPLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               dlf_valid,
    input  logic [IN_W-1:0]    dlf_out,
    input  logic [SHIFT_W-1:0] shift_req,
    input  logic               shift_load,
    input  logic               auto_gear,
    input  logic [SHIFT_W-1:0] gear_target,
    input  logic               round_en,
    output logic [OUT_W-1:0]   vco_val,
    output logic               vco_valid,
    output logic [SHIFT_W-1:0] cur_shift,
    output logic               sat,
    output logic               gear_done
);

    localparam int MAX_SHIFT = IN_W - OUT_W;
    // MAX_SHIFT may exceed what the shift fields can represent. In that case
    // no clamp is needed, so the limit is capped to the field range.
    localparam int SHIFT_FIELD_MAX = (1 << SHIFT_W) - 1;
    localparam int MAX_CAP = (MAX_SHIFT > SHIFT_FIELD_MAX) ? SHIFT_FIELD_MAX : MAX_SHIFT;
    localparam logic [SHIFT_W-1:0] MAX_SHIFT_V = SHIFT_W'(MAX_CAP);
    localparam int CNT_W = (GEAR_SAMPLES > 1) ? $clog2(GEAR_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GEAR_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MANUAL,
        S_GEAR,
        S_HOLD
    } state_t;

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        return (s > MAX_SHIFT_V) ? MAX_SHIFT_V : s;
    endfunction

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] cur_shift_q, cur_shift_d;
    logic [CNT_W-1:0]   gear_cnt_q, gear_cnt_d;
    logic [OUT_W-1:0]   vco_val_q, vco_val_d;
    logic               vco_valid_q, vco_valid_d;
    logic               sat_q, sat_d;

    logic [SHIFT_W-1:0] use_shift;
    logic [SHIFT_W-1:0] target_c;
    logic               accept;
    logic [IN_W:0]      round_add;
    logic [IN_W:0]      sum;
    logic [IN_W:0]      q;
    logic               q_sat;

    always_comb begin
        state_d     = state_q;
        cur_shift_d = cur_shift_q;
        gear_cnt_d  = gear_cnt_q;
        vco_val_d   = vco_val_q;
        vco_valid_d = 1'b0;
        sat_d       = 1'b0;
        accept      = 1'b0;
        use_shift   = cur_shift_q;
        target_c    = clamp_shift(gear_target);
        round_add   = '0;
        sum         = '0;
        q           = '0;
        q_sat       = 1'b0;

        if (!enable) begin
            state_d   = S_IDLE;
            vco_val_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Samples are not accepted in the cycle that leaves IDLE.
                    state_d     = auto_gear ? S_GEAR : S_MANUAL;
                    cur_shift_d = clamp_shift(shift_req);
                    gear_cnt_d  = '0;
                    vco_val_d   = '0;
                end
                S_MANUAL: begin
                    // A shift load in the same cycle as a sample applies to that sample.
                    if (shift_load) begin
                        use_shift   = clamp_shift(shift_req);
                        cur_shift_d = use_shift;
                    end
                    accept = dlf_valid;
                end
                S_GEAR: begin
                    // A sample that triggers a step still converts with the pre-step shift.
                    accept = dlf_valid;
                    if (dlf_valid) begin
                        if (gear_cnt_q == CNT_LAST) begin
                            gear_cnt_d = '0;
                            if (cur_shift_q < target_c) begin
                                cur_shift_d = cur_shift_q + 1'b1;
                            end
                        end else begin
                            gear_cnt_d = gear_cnt_q + 1'b1;
                        end
                    end
                    if (cur_shift_q >= target_c) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    accept = dlf_valid;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // The sum is one bit wider than dlf_out, so the rounding carry cannot be lost.
        if (round_en && (use_shift != '0)) begin
            round_add = {{IN_W{1'b0}}, 1'b1} << (use_shift - 1'b1);
        end
        sum   = {1'b0, dlf_out} + round_add;
        q     = sum >> use_shift;
        q_sat = |q[IN_W:OUT_W];

        if (accept) begin
            vco_val_d   = q_sat ? {OUT_W{1'b1}} : q[OUT_W-1:0];
            vco_valid_d = 1'b1;
            sat_d       = q_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_shift_q <= '0;
            gear_cnt_q  <= '0;
            vco_val_q   <= '0;
            vco_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_shift_q <= cur_shift_d;
            gear_cnt_q  <= gear_cnt_d;
            vco_val_q   <= vco_val_d;
            vco_valid_q <= vco_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign vco_val   = vco_val_q;
    assign vco_valid = vco_valid_q;
    assign cur_shift = cur_shift_q;
    assign sat       = sat_q;
    assign gear_done = (state_q == S_HOLD);

endmodule

// File: tb/tb_dlf_gain_shifter.sv
// tb/tb_dlf_gain_shifter.sv - self-checking bench for dlf_gain_shifter
module tb_dlf_gain_shifter;

    localparam int IN_W  = 12;
    localparam int OUT_W = 5;
    localparam int SW    = 3;
    localparam int OMAX  = (1 << OUT_W) - 1;

    logic          clk = 1'b0;
    logic          reset, enable, dlf_valid, shift_load, auto_gear, round_en;
    logic [IN_W-1:0] dlf_out;
    logic [SW-1:0] shift_req, gear_target;
    logic [OUT_W-1:0] vco_val;
    logic          vco_valid, sat, gear_done;
    logic [SW-1:0] cur_shift;

    logic [OUT_W-1:0] vco_val2;
    logic          vco_valid2, sat2, gear_done2;
    logic [SW-1:0] cur_shift2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dlf_gain_shifter #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SW), .GEAR_SAMPLES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dlf_valid(dlf_valid),
        .dlf_out(dlf_out), .shift_req(shift_req), .shift_load(shift_load),
        .auto_gear(auto_gear), .gear_target(gear_target), .round_en(round_en),
        .vco_val(vco_val), .vco_valid(vco_valid), .cur_shift(cur_shift),
        .sat(sat), .gear_done(gear_done)
    );

    dlf_gain_shifter #(.IN_W(10), .OUT_W(OUT_W), .SHIFT_W(SW), .GEAR_SAMPLES(4)) dut10 (
        .clk(clk), .reset(reset), .enable(enable), .dlf_valid(dlf_valid),
        .dlf_out(dlf_out[9:0]), .shift_req(shift_req), .shift_load(shift_load),
        .auto_gear(auto_gear), .gear_target(gear_target), .round_en(round_en),
        .vco_val(vco_val2), .vco_valid(vco_valid2), .cur_shift(cur_shift2),
        .sat(sat2), .gear_done(gear_done2)
    );

    typedef struct {
        int dlf;
        int sreq;
        int rnd;
        int ev;
        int es;
    } vec_t;

    vec_t tbl[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference conversion written directly with integer arithmetic.
    function automatic void ref_conv(input int dlf, input int s, input int rnd,
                                     output int v, output int st);
        int sum;
        int q;
        sum = dlf + ((rnd != 0 && s > 0) ? (1 << (s - 1)) : 0);
        q   = sum / (1 << s);
        if (q > OMAX) begin
            v  = OMAX;
            st = 1;
        end else begin
            v  = q;
            st = 0;
        end
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        int ms, last_val, ev, es, v, r, ld;

        tbl[0] = '{32'h0A8, 3, 0, 21, 0};
        tbl[1] = '{32'h0AC, 3, 1, 22, 0};
        tbl[2] = '{32'h0FF, 0, 0, 31, 1};
        tbl[3] = '{32'h3E0, 5, 0, 31, 0};
        tbl[4] = '{32'h3F0, 5, 1, 31, 1};
        tbl[5] = '{32'h000, 7, 1, 0, 0};
        tbl[6] = '{32'hFFF, 7, 1, 31, 1};
        tbl[7] = '{32'hFFF, 7, 0, 31, 0};
        tbl[8] = '{32'h0C0, 7, 1, 2, 0};
        tbl[9] = '{32'h0BF, 7, 1, 1, 0};

        reset = 1'b1; enable = 1'b0; dlf_valid = 1'b0; dlf_out = '0;
        shift_req = '0; shift_load = 1'b0; auto_gear = 1'b0;
        gear_target = '0; round_en = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("reset_vco_val", int'(vco_val), 0);
        chk("reset_vco_valid", int'(vco_valid), 0);
        chk("reset_cur_shift", int'(cur_shift), 0);
        chk("reset_sat", int'(sat), 0);
        chk("reset_gear_done", int'(gear_done), 0);

        // Leave IDLE with a strobe present: the strobe must be ignored.
        enable = 1'b1; shift_req = 3'd3; dlf_valid = 1'b1; dlf_out = 12'h0A8;
        step();
        chk("idle_exit_no_valid", int'(vco_valid), 0);
        chk("idle_exit_shift", int'(cur_shift), 3);
        chk("idle_exit_shift_in10", int'(cur_shift2), 3);

        // Each vector loads its shift in the same cycle as the sample.
        for (int i = 0; i < 10; i++) begin
            dlf_out = tbl[i].dlf[IN_W-1:0];
            shift_req = tbl[i].sreq[SW-1:0];
            round_en = tbl[i].rnd[0];
            shift_load = 1'b1; dlf_valid = 1'b1;
            step();
            chk($sformatf("tbl%0d_val", i), int'(vco_val), tbl[i].ev);
            chk($sformatf("tbl%0d_valid", i), int'(vco_valid), 1);
            chk($sformatf("tbl%0d_sat", i), int'(sat), tbl[i].es);
        end
        shift_load = 1'b0; dlf_valid = 1'b0;
        step();
        chk("no_strobe_valid", int'(vco_valid), 0);
        chk("no_strobe_hold_val", int'(vco_val), 1);
        chk("clamp_in12", int'(cur_shift), 7);
        chk("clamp_in10", int'(cur_shift2), 5);

        // Randomized MANUAL traffic against the reference model.
        ms = 7; last_val = 1;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r  = int'($urandom_range(0, 1));
            v  = int'($urandom_range(0, 4095));
            shift_req = SW'($urandom_range(0, 7));
            dlf_valid = ($urandom_range(0, 9) < 7);
            shift_load = ld[0]; round_en = r[0]; dlf_out = v[IN_W-1:0];
            if (ld != 0) ms = imin(int'(shift_req), IN_W - OUT_W);
            step();
            if (dlf_valid) begin
                ref_conv(v, ms, r, ev, es);
                chk($sformatf("rnd%0d_val", i), int'(vco_val), ev);
                chk($sformatf("rnd%0d_sat", i), int'(sat), es);
                chk($sformatf("rnd%0d_valid", i), int'(vco_valid), 1);
                last_val = ev;
            end else begin
                chk($sformatf("rnd%0d_novalid", i), int'(vco_valid), 0);
                chk($sformatf("rnd%0d_held", i), int'(vco_val), last_val);
                chk($sformatf("rnd%0d_nosat", i), int'(sat), 0);
            end
            chk($sformatf("rnd%0d_shift", i), int'(cur_shift), ms);
        end
        shift_load = 1'b0; dlf_valid = 1'b0; round_en = 1'b0;

        enable = 1'b0;
        step();
        chk("disable_val", int'(vco_val), 0);
        chk("disable_sat", int'(sat), 0);
        chk("disable_done", int'(gear_done), 0);

        // Gear run: 4 samples per step, start 1, target 3.
        enable = 1'b1; auto_gear = 1'b1; shift_req = 3'd1; gear_target = 3'd3;
        step();
        chk("gear_start_shift", int'(cur_shift), 1);
        chk("gear_start_done", int'(gear_done), 0);
        dlf_out = 12'h030; dlf_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            es = imin(1 + (k - 1) / 4, 3);
            chk($sformatf("gear%0d_val", k), int'(vco_val), 48 >> es);
            chk($sformatf("gear%0d_shift", k), int'(cur_shift), imin(1 + k / 4, 3));
            chk($sformatf("gear%0d_done", k), int'(gear_done), (k >= 9) ? 1 : 0);
        end
        dlf_valid = 1'b0; shift_load = 1'b1; shift_req = 3'd0;
        step();
        chk("hold_ignores_load", int'(cur_shift), 3);
        chk("hold_done", int'(gear_done), 1);
        shift_load = 1'b0;

        // Drop enable mid-gear, then confirm the count restarts.
        enable = 1'b0;
        step();
        enable = 1'b1; shift_req = 3'd1;
        step();
        dlf_valid = 1'b1;
        step(); step();
        chk("midgear_shift", int'(cur_shift), 1);
        enable = 1'b0;
        step();
        chk("drop_val", int'(vco_val), 0);
        chk("drop_valid", int'(vco_valid), 0);
        chk("drop_done", int'(gear_done), 0);
        enable = 1'b1; dlf_valid = 1'b0;
        step();
        chk("reentry_shift", int'(cur_shift), 1);
        dlf_valid = 1'b1;
        step(); step(); step();
        chk("restart_cnt3_shift", int'(cur_shift), 1);
        step();
        chk("restart_cnt4_shift", int'(cur_shift), 2);
        dlf_valid = 1'b0;

        // A start shift already above the target goes straight to HOLD.
        enable = 1'b0;
        step();
        enable = 1'b1; shift_req = 3'd5; gear_target = 3'd3;
        step();
        chk("above_tgt_shift", int'(cur_shift), 5);
        chk("above_tgt_done0", int'(gear_done), 0);
        step();
        chk("above_tgt_done1", int'(gear_done), 1);
        chk("above_tgt_frozen", int'(cur_shift), 5);

        // A reset that coincides with a strobe must win.
        reset = 1'b1; dlf_valid = 1'b1;
        step();
        chk("reset_with_strobe_valid", int'(vco_valid), 0);
        chk("reset_with_strobe_shift", int'(cur_shift), 0);
        chk("reset_with_strobe_done", int'(gear_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dlf_gain_shifter.md
# dlf_gain_shifter

Parametrised, registered gain stage between the digital loop filter and the DCO/VCO control word. It selects an OUT_W-bit window of the unsigned DLF output using a programmable right-shift, with round-half-up and saturation. The active shift is applied on sample boundaries only. An optional automatic gear-shift mode steps the shift up (lowering loop gain) after a fixed number of samples, for fast acquisition followed by low-bandwidth tracking.

## Interface
Parameters:
- IN_W, 12, DLF output width (unsigned)
- OUT_W, 5, VCO control word width; must be less than IN_W
- SHIFT_W, 3, width of shift fields; MAX_SHIFT = IN_W-OUT_W (derived)
- GEAR_SAMPLES, 64, accepted samples per gear step; must be at least 1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  block enable; low forces IDLE
- dlf_valid  in  1  one-cycle strobe, new dlf_out sample
- dlf_out  in  IN_W  unsigned loop-filter output
- shift_req  in  SHIFT_W  requested shift (manual value / gear start value)
- shift_load  in  1  pulse, load shift_req in MANUAL
- auto_gear  in  1  mode select, sampled only on IDLE exit
- gear_target  in  SHIFT_W  final shift in auto mode
- round_en  in  1  1 = round half up, 0 = truncate
- vco_val  out  OUT_W  registered control word
- vco_valid  out  1  one-cycle strobe, vco_val updated
- cur_shift  out  SHIFT_W  active shift
- sat  out  1  one-cycle pulse with vco_valid when the output saturated
- gear_done  out  1  high in HOLD

## Operation
- Clamp: any shift value (shift_req, gear_target) greater than MAX_SHIFT is treated as MAX_SHIFT.
- Conversion on an accepted sample (dlf_valid=1 in MANUAL/GEAR/HOLD):
  - sum = dlf_out + (round_en && s>0 ? 2^(s-1) : 0), computed in IN_W+1 bits.
  - q = sum >> s.
  - If q > 2^OUT_W-1: vco_val = all ones and sat = 1. Otherwise vco_val = q[OUT_W-1:0] and sat = 0.
- States:
  - IDLE: vco_val held at 0; vco_valid=0.
    - If enable=1: sample auto_gear. auto_gear=0 → MANUAL; auto_gear=1 → GEAR.
    - On either transition, cur_shift = clamp(shift_req) and gear_cnt = 0.
  - MANUAL: shift_load=1 sets cur_shift = clamp(shift_req).
  - GEAR: shift_load ignored. Each accepted sample increments gear_cnt.
    - When gear_cnt = GEAR_SAMPLES-1 on an accepted sample: gear_cnt = 0, and cur_shift increments by 1 if below clamp(gear_target).
    - Whenever cur_shift ≥ clamp(gear_target) → HOLD. This includes a start value already at or above the target, which goes to HOLD on the next cycle with no shift change.
  - HOLD: shift_load ignored; cur_shift frozen; gear_done=1.
  - Any state with enable=0 → IDLE on the next edge. vco_val becomes 0; sat and gear_done clear.
- Shift used for a sample is the value after any same-cycle shift_load in MANUAL. In GEAR, a sample that triggers a step uses the pre-step shift; the new shift applies from the next sample.

## Timing
- Reset values: state IDLE, vco_val=0, vco_valid=0, cur_shift=0, sat=0, gear_done=0, gear_cnt=0. reset overrides all other inputs.
- Latency: dlf_valid at edge N → vco_val, vco_valid, sat valid after edge N+1. vco_valid is exactly one cycle wide per accepted sample. Back-to-back strobes are supported at full rate.
- dlf_valid in IDLE, or in the cycle enable is sampled high from IDLE: ignored, no vco_valid.
- cur_shift updates one cycle after shift_load or after the gear-step sample.
- gear_done rises in the cycle HOLD is entered.
- Reset or enable drop mid-GEAR: gear progress is lost; re-entry restarts from clamp(shift_req).
- vco_val changes only on accepted samples, reset or disable. Shift changes never alter vco_val on their own (glitch-free).

## Test plan
- Reset, then enable=1, auto_gear=0, shift_req=3, round_en=0, dlf_out=0x0A8 strobe → one cycle later vco_val=21, vco_valid=1, sat=0.
- Same setup with round_en=1, dlf_out=0x0AC → vco_val=22 (172+4=176, >>3). With shift=0, dlf_out=0x0FF → vco_val=31, sat=1.
- Request exceeding MAX_SHIFT: shift_req=7 → cur_shift=7 (MAX_SHIFT=7). With IN_W=10 and shift_req=7 → cur_shift=5.
- MANUAL: shift_load with shift_req=5 in the same cycle as dlf_out=0x3E0 strobe → vco_val=31 using shift 5. No vco_valid without dlf_valid.
- GEAR with GEAR_SAMPLES=4, shift_req=1, gear_target=3, continuous strobes → cur_shift 1→2 after the 4th sample, 2→3 after the 8th, then HOLD with gear_done=1. Later shift_load has no effect.
- enable dropped mid-GEAR after 2 samples → next cycle vco_val=0, gear_done=0. Re-enable restarts at shift_req with gear_cnt=0. reset asserted together with dlf_valid → no vco_valid.
